// File: rtl/score_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : score_display_mux
// Function : BCD scoreboard with saturation, hit-count LED bar and multiplexed
//            active-low 7-segment display with leading-zero blanking.
//            Optional high-score register enabled by macro HIGH_SCORE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module score_display_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int POINTS_PER_HIT = 1,
  parameter int REFRESH_DIV    = 100000
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic                  alien_hit,
  input  logic                  score_clear,
`ifdef HIGH_SCORE_EN
  input  logic                  game_over,
  input  logic                  show_high,
  output logic                  new_high,
`endif
  output logic [15:0]           led,
  output logic                  a,
  output logic                  b,
  output logic                  c,
  output logic                  d,
  output logic                  e,
  output logic                  f,
  output logic                  g,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  overflow
);

  localparam int SCORE_W = 4 * NUM_DIGITS;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CTR_W   = $clog2(REFRESH_DIV);
  localparam logic [CTR_W-1:0]   CTR_MAX   = CTR_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCORE_W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  logic                 alien_hit_q;
  logic                 hit;
  logic [SCORE_W-1:0]   score;
  logic [SCORE_W-1:0]   sum_score;
  logic                 carry_out;
  logic [SCORE_W-1:0]   disp;
  logic [3:0]           digits [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] upper_zero;
  logic [CTR_W-1:0]     refresh_ctr;
  logic [IDX_W-1:0]     digit_idx;
  logic [6:0]           seg;
  logic                 blank;

  function automatic logic [6:0] seg_code(input logic [3:0] val);
    case (val)
      4'd0:    seg_code = 7'b0000001;
      4'd1:    seg_code = 7'b1001111;
      4'd2:    seg_code = 7'b0010010;
      4'd3:    seg_code = 7'b0000110;
      4'd4:    seg_code = 7'b1001100;
      4'd5:    seg_code = 7'b0100100;
      4'd6:    seg_code = 7'b0100000;
      4'd7:    seg_code = 7'b0001111;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0000100;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  assign hit = alien_hit & ~alien_hit_q;

  // Decimal ripple add; a carry out of the top digit means saturation.
  always_comb begin
    logic [4:0] cin;
    logic [4:0] s;
    sum_score = '0;
    cin       = 5'(POINTS_PER_HIT);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      s = {1'b0, score[i*4 +: 4]} + cin;
      if (s > 5'd9) begin
        sum_score[i*4 +: 4] = 4'(s - 5'd10);
        cin                 = 5'd1;
      end else begin
        sum_score[i*4 +: 4] = s[3:0];
        cin                 = 5'd0;
      end
    end
    carry_out = cin[0];
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      alien_hit_q <= 1'b0;
      score       <= '0;
      led         <= '0;
      overflow    <= 1'b0;
    end else begin
      alien_hit_q <= alien_hit;
      if (score_clear) begin
        score    <= '0;
        led      <= '0;
        overflow <= 1'b0;
      end else if (hit) begin
        if (carry_out) begin
          score    <= ALL_NINES;
          overflow <= 1'b1;
        end else begin
          score <= sum_score;
        end
        if (led != 16'hFFFF)
          led <= led + 16'd1;
      end
    end
  end

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_score;
  logic               game_over_q;

  // Packed BCD with the most significant digit on top compares like binary.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      high_score  <= '0;
      game_over_q <= 1'b0;
      new_high    <= 1'b0;
    end else begin
      game_over_q <= game_over;
      new_high    <= 1'b0;
      if (game_over && !game_over_q && (score > high_score)) begin
        high_score <= score;
        new_high   <= 1'b1;
      end
    end
  end

  assign disp = show_high ? high_score : score;
`else
  assign disp = score;
`endif

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digits
    assign digits[k] = disp[k*4 +: 4];
  end

  always_comb begin
    logic all_zero;
    all_zero   = 1'b1;
    upper_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero      = all_zero & (digits[k] == 4'd0);
      upper_zero[k] = all_zero;
    end
  end

  assign blank = (digit_idx != '0) && upper_zero[digit_idx];

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      refresh_ctr <= '0;
      digit_idx   <= '0;
    end else if (refresh_ctr == CTR_MAX) begin
      refresh_ctr <= '0;
      digit_idx   <= (digit_idx == IDX_MAX) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      refresh_ctr <= refresh_ctr + CTR_W'(1);
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      an  <= '1;
      seg <= 7'b1111111;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << digit_idx);
      seg <= blank ? 7'b1111111 : seg_code(digits[digit_idx]);
    end
  end

  assign {a, b, c, d, e, f, g} = seg;
  assign dp = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_score_display_mux.sv
`default_nettype none
// Bench for score_display_mux: table-driven score/LED/display checks plus
// directed sequences for latency, clear priority, async reset and high score.
module tb_score_display_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, alien_hit, alien_hit7, score_clear;
  logic [15:0] led, led7;
  logic [6:0]  seg, seg7;
  logic        dp, dp7, ovf, ovf7;
  logic [3:0]  an, an7;
`ifdef HIGH_SCORE_EN
  logic game_over, show_high, new_high, new_high7;
`endif

  score_display_mux #(.NUM_DIGITS(4), .POINTS_PER_HIT(1), .REFRESH_DIV(4)) dut (
    .clk_100MHz(clk), .reset(reset), .alien_hit(alien_hit), .score_clear(score_clear),
`ifdef HIGH_SCORE_EN
    .game_over(game_over), .show_high(show_high), .new_high(new_high),
`endif
    .led(led), .a(seg[6]), .b(seg[5]), .c(seg[4]), .d(seg[3]), .e(seg[2]),
    .f(seg[1]), .g(seg[0]), .dp(dp), .an(an), .overflow(ovf));

  score_display_mux #(.NUM_DIGITS(4), .POINTS_PER_HIT(7), .REFRESH_DIV(4)) dut7 (
    .clk_100MHz(clk), .reset(reset), .alien_hit(alien_hit7), .score_clear(score_clear),
`ifdef HIGH_SCORE_EN
    .game_over(1'b0), .show_high(1'b0), .new_high(new_high7),
`endif
    .led(led7), .a(seg7[6]), .b(seg7[5]), .c(seg7[4]), .d(seg7[3]), .e(seg7[2]),
    .f(seg7[1]), .g(seg7[0]), .dp(dp7), .an(an7), .overflow(ovf7));

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};
  logic [6:0] cap   [4];
  logic [6:0] cap7  [4];
  logic       onehot_ok;

  typedef struct {
    bit clear;
    int hits;
    int hold;
    int exp_score;
    int exp_led;
    bit exp_ovf;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected pattern for digit k: blank when every digit from k upward is 0.
  function automatic logic [6:0] exp_seg(input int score, input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (k > 0 && score < p) return 7'b1111111;
    return seg_tab[(score / p) % 10];
  endfunction

  task automatic apply_hits(input int which, input int n, input int hold);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (which == 0) alien_hit = 1'b1; else alien_hit7 = 1'b1;
      repeat (hold) @(negedge clk);
      alien_hit = 1'b0; alien_hit7 = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk); score_clear = 1'b1;
    @(negedge clk); score_clear = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic scan();
    for (int k = 0; k < 4; k++) begin cap[k] = 7'bx; cap7[k] = 7'bx; end
    onehot_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(an inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) onehot_ok = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (an == ~(4'b0001 << k)) cap[k] = seg;
        if (an7 == ~(4'b0001 << k)) cap7[k] = seg7;
      end
    end
  endtask

  task automatic check_display(input string tag, input int score);
    scan();
    check({tag, "_an_onehot"}, 32'(onehot_ok), 32'd1);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_digit%0d", tag, k), 32'(cap[k]), 32'(exp_seg(score, k)));
  endtask

  initial begin
    vecs[0] = '{0, 3,    2,  3,    3,     0};
    vecs[1] = '{0, 1,    50, 4,    4,     0};
    vecs[2] = '{1, 0,    0,  0,    0,     0};
    vecs[3] = '{0, 10,   1,  10,   10,    0};
    vecs[4] = '{0, 95,   1,  105,  105,   0};
    vecs[5] = '{1, 0,    0,  0,    0,     0};
    vecs[6] = '{0, 9998, 1,  9998, 9998,  0};
    vecs[7] = '{0, 3,    1,  9999, 10001, 1};
    vecs[8] = '{1, 0,    0,  0,    0,     0};

    reset = 1'b1; alien_hit = 1'b0; alien_hit7 = 1'b0; score_clear = 1'b0;
`ifdef HIGH_SCORE_EN
    game_over = 1'b0; show_high = 1'b0;
`endif
    #50;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    #50 reset = 1'b0;
    check("rel_led", 32'(led), 32'd0);
    check("rel_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    check("rel_an", 32'(an), 32'b1110);
    check("rel_seg", 32'(seg), 32'b0000001);
    check("rel_dp", 32'(dp), 32'd1);

    apply_hits(1, 2, 1);
    scan();
    check("pph7_digit0", 32'(cap7[0]), 32'b1001100);
    check("pph7_digit1", 32'(cap7[1]), 32'b1001111);
    check("pph7_digit2", 32'(cap7[2]), 32'h7F);
    check("pph7_digit3", 32'(cap7[3]), 32'h7F);
    check("pph7_led", 32'(led7), 32'd2);

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].clear) do_clear();
      else apply_hits(0, vecs[v].hits, vecs[v].hold);
      check($sformatf("v%0d_led", v), 32'(led), 32'(vecs[v].exp_led));
      check($sformatf("v%0d_ovf", v), 32'(ovf), 32'(vecs[v].exp_ovf));
      check_display($sformatf("v%0d", v), vecs[v].exp_score);
    end

    // One-cycle latency from the rising edge to the count.
    @(negedge clk); alien_hit = 1'b1;
    check("lat_before", 32'(led), 32'd0);
    @(negedge clk);
    check("lat_after", 32'(led), 32'd1);
    alien_hit = 1'b0;
    repeat (2) @(negedge clk);

    // Clear wins over a coincident hit, and that hit is not deferred.
    @(negedge clk); alien_hit = 1'b1; score_clear = 1'b1;
    @(negedge clk); score_clear = 1'b0;
    repeat (3) @(negedge clk);
    check("clr_prio_led", 32'(led), 32'd0);
    alien_hit = 1'b0;
    check_display("clr_prio", 0);

    // Asynchronous reset in the middle of a scan.
    apply_hits(0, 3, 1);
    apply_hits(0, 0, 1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_an", 32'(an), 32'hF);
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_led", 32'(led), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("arst_restart_an", 32'(an), 32'b1110);
    check("arst_restart_seg", 32'(seg), 32'b0000001);

`ifdef HIGH_SCORE_EN
    begin
      logic saw;
      apply_hits(0, 12, 1);
      @(negedge clk); game_over = 1'b1;
      @(negedge clk);
      check("hs_pulse", 32'(new_high), 32'd1);
      game_over = 1'b0;
      @(negedge clk);
      check("hs_pulse_end", 32'(new_high), 32'd0);
      show_high = 1'b1;
      check_display("hs_show", 12);
      show_high = 1'b0;
      do_clear();
      apply_hits(0, 5, 1);
      saw = 1'b0;
      @(negedge clk); game_over = 1'b1;
      repeat (3) begin @(negedge clk); saw = saw | new_high; end
      game_over = 1'b0;
      check("hs_no_pulse", 32'(saw), 32'd0);
      show_high = 1'b1;
      check_display("hs_keep", 12);
      show_high = 1'b0;
      check_display("hs_score", 5);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
